// File: rtl/fma_pkg.sv
// Width constants and the stage-1 payload shared by the final adder, LZA and normaliser.
// Widths derive from the single-precision mantissa; every FMA back-end block imports this package.
package fma_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int LOW_W  = 2*MANT_W + 2;
    localparam int HIGH_W = MANT_W + 4;
    localparam int SUM_W  = 3*MANT_W + 5;

    typedef struct packed {
        logic [LOW_W-1:0]  ls;
        logic              lc;
        logic [LOW_W-1:0]  lsi;
        logic              lci;
        logic [HIGH_W-1:0] a_high;
        logic              sub;
        logic              exp_mv_sign;
        logic              mv_halt;
        logic              sign_aligned;
        logic              bc_special;
    } s1_payload_t;

endpackage

// File: rtl/grand_adder_pipe_if.sv
// Upstream (CSA/alignment) and downstream (LZA/normaliser) handshake bundle for the final adder.
// The slave modport is the adder's view; master is the view of whatever drives and consumes it.
interface grand_adder_pipe_if;
    import fma_pkg::*;

    logic              valid_i;
    logic              ready_o;
    logic [LOW_W-1:0]  csa_sum_i;
    logic [LOW_W-1:0]  csa_carry_i;
    logic              sub_i;
    logic              corr_sign_i;
    logic              exp_mv_sign_i;
    logic              mv_halt_i;
    logic              sign_aligned_i;
    logic [HIGH_W-1:0] a_high_i;
    logic              bc_special_i;
    logic              valid_o;
    logic              ready_i;
    logic [SUM_W-1:0]  pos_sum_o;
    logic              adder_sign_o;
    logic              sign_flip_o;
    logic              minus_sticky_o;

    modport slave (
        input  valid_i, csa_sum_i, csa_carry_i, sub_i, corr_sign_i, exp_mv_sign_i,
               mv_halt_i, sign_aligned_i, a_high_i, bc_special_i, ready_i,
        output ready_o, valid_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
    );

    modport master (
        output valid_i, csa_sum_i, csa_carry_i, sub_i, corr_sign_i, exp_mv_sign_i,
               mv_halt_i, sign_aligned_i, a_high_i, bc_special_i, ready_i,
        input  ready_o, valid_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
    );

endinterface

// File: rtl/gadd_low_eac.sv
// Dual low adder: S + C and its two's-complement negation, both with carry-out into the high part.
// Purely combinational, no backpressure of its own.
module gadd_low_eac
    import fma_pkg::*;
(
    input  logic [LOW_W-1:0] i_csa_sum,
    input  logic [LOW_W-1:0] i_csa_carry,
    input  logic             i_sub,
    input  logic             i_corr_sign,
    input  logic             i_exp_mv_sign,
    output logic [LOW_W-1:0] o_ls,
    output logic             o_lc,
    output logic [LOW_W-1:0] o_lsi,
    output logic             o_lci
);

    localparam logic [LOW_W:0] TWO = (LOW_W+1)'(2);

    logic           w_cpc;
    logic [LOW_W:0] w_addend;
    logic [LOW_W:0] w_sum;
    logic [LOW_W:0] w_sum_inv;

    // The carry MSB is replaced by the Wallace sign-extension correction; sub enters as the +1 LSB.
    assign w_cpc     = i_exp_mv_sign ? 1'b0 : (~i_corr_sign ^ i_csa_carry[LOW_W-1]);
    assign w_addend  = {w_cpc, i_csa_carry[LOW_W-2:0], i_sub};
    assign w_sum     = {1'b0, i_csa_sum} + w_addend;
    assign w_sum_inv = {1'b1, ~i_csa_sum} + ~w_addend + TWO;

    assign {o_lc, o_ls}   = w_sum;
    assign {o_lci, o_lsi} = w_sum_inv;

endmodule

// File: rtl/grand_adder_pipe.sv
// FMA final adder: merges CSA sum/carry with aligned addend high part into magnitude, sign, flip, sticky.
// Latency 2, one beat per cycle; ready_o drops only when both stages hold data and ready_i is low.
module grand_adder_pipe
    import fma_pkg::*;
#(
    parameter int PARM_EXP  = EXP_W,
    parameter int PARM_MANT = MANT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    grand_adder_pipe_if.slave bus
);

    localparam int M = PARM_MANT;
    localparam logic [M+2:0] HSI_ONE = (M+3)'(1);

    if (PARM_MANT != MANT_W || PARM_EXP != EXP_W) begin : g_bad_width
        $error("grand_adder_pipe: parameters must match the widths in fma_pkg");
    end

    logic              w_s1_adv;
    logic              w_ready;
    logic [LOW_W-1:0]  w_ls;
    logic              w_lc;
    logic [LOW_W-1:0]  w_lsi;
    logic              w_lci;
    s1_payload_t       w_s1_next;

    logic              r_s1_vld;
    s1_payload_t       r_s1;

    logic [HIGH_W-1:0] w_hs;
    logic [M+2:0]      w_hsi;
    logic [HIGH_W-1:0] w_mv_diff;
    logic              w_flip;
    logic              w_sign;
    logic [SUM_W-1:0]  w_pos_sum;

    logic              r_s2_vld;
    logic [SUM_W-1:0]  r_pos_sum;
    logic              r_sign;
    logic              r_flip;
    logic              r_sticky;

    assign w_s1_adv = ~r_s2_vld | bus.ready_i;
    assign w_ready  = ~r_s1_vld | w_s1_adv;

    gadd_low_eac u_low_eac (
        .i_csa_sum     (bus.csa_sum_i),
        .i_csa_carry   (bus.csa_carry_i),
        .i_sub         (bus.sub_i),
        .i_corr_sign   (bus.corr_sign_i),
        .i_exp_mv_sign (bus.exp_mv_sign_i),
        .o_ls          (w_ls),
        .o_lc          (w_lc),
        .o_lsi         (w_lsi),
        .o_lci         (w_lci)
    );

    always_comb begin
        w_s1_next              = '0;
        w_s1_next.ls           = w_ls;
        w_s1_next.lc           = w_lc;
        w_s1_next.lsi          = w_lsi;
        w_s1_next.lci          = w_lci;
        w_s1_next.a_high       = bus.a_high_i;
        w_s1_next.sub          = bus.sub_i;
        w_s1_next.exp_mv_sign  = bus.exp_mv_sign_i;
        w_s1_next.mv_halt      = bus.mv_halt_i;
        w_s1_next.sign_aligned = bus.sign_aligned_i;
        w_s1_next.bc_special   = bus.bc_special_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            if (flush_i)
                r_s1_vld <= 1'b0;
            else if (w_ready)
                r_s1_vld <= bus.valid_i;
            if (bus.valid_i && w_ready && !flush_i)
                r_s1 <= w_s1_next;
        end
    end

    // High part: straight sum for the positive case, pre-negated for the flipped case.
    assign w_hs      = r_s1.a_high + {{(HIGH_W-1){1'b0}}, r_s1.lc};
    assign w_hsi     = r_s1.lci ? ~r_s1.a_high[M+2:0] : (~r_s1.a_high[M+2:0] - HSI_ONE);
    assign w_mv_diff = {r_s1.a_high[M+2:0], 1'b0} - {{(HIGH_W-1){1'b0}}, ~r_s1.bc_special};
    assign w_flip    = w_hs[HIGH_W-1];
    assign w_sign    = r_s1.exp_mv_sign ? r_s1.sign_aligned : (w_flip ^ r_s1.sign_aligned);

    always_comb begin
        w_pos_sum = {w_hs[M+2:0], r_s1.ls};
        if (r_s1.mv_halt)
            w_pos_sum = {{(SUM_W-LOW_W){1'b0}}, r_s1.ls};
        else if (r_s1.exp_mv_sign)
            w_pos_sum = r_s1.sub ? {w_mv_diff, {(2*M+1){1'b0}}}
                                 : {r_s1.a_high[M+2:0], {LOW_W{1'b0}}};
        else if (w_flip)
            w_pos_sum = {w_hsi, r_s1.lsi};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_vld  <= 1'b0;
            r_pos_sum <= '0;
            r_sign    <= 1'b0;
            r_flip    <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            if (flush_i)
                r_s2_vld <= 1'b0;
            else if (w_s1_adv)
                r_s2_vld <= r_s1_vld;
            if (r_s1_vld && w_s1_adv && !flush_i) begin
                r_pos_sum <= w_pos_sum;
                r_sign    <= w_sign;
                r_flip    <= w_flip;
                r_sticky  <= r_s1.exp_mv_sign & ~r_s1.bc_special;
            end
        end
    end

    assign bus.ready_o        = w_ready;
    assign bus.valid_o        = r_s2_vld;
    assign bus.pos_sum_o      = r_pos_sum;
    assign bus.adder_sign_o   = r_sign;
    assign bus.sign_flip_o    = r_flip;
    assign bus.minus_sticky_o = r_sticky;

endmodule

// File: tb/tb_grand_adder_pipe.sv
// Directed vectors for grand_adder_pipe; expected responses queue at accept and a monitor checks them on output.
module tb_grand_adder_pipe;
    import fma_pkg::*;

    typedef struct {
        logic [LOW_W-1:0]  s;
        logic [LOW_W-1:0]  c;
        logic              sub;
        logic              corr;
        logic              emv;
        logic              halt;
        logic              sa;
        logic              bc;
        logic [HIGH_W-1:0] ah;
        logic [SUM_W-1:0]  e_sum;
        logic              e_sign;
        logic              e_flip;
        logic              e_sticky;
    } vec_t;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic             sign;
        logic             flip;
        logic             sticky;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic flush_i;
    always #5 clk_i = ~clk_i;

    grand_adder_pipe_if ifc ();

    grand_adder_pipe dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (ifc)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[11];

    function automatic vec_t mk(input logic [LOW_W-1:0] s, input logic [LOW_W-1:0] c,
                                input logic sub, input logic corr, input logic emv,
                                input logic halt, input logic sa, input logic bc,
                                input logic [HIGH_W-1:0] ah, input logic [SUM_W-1:0] es,
                                input logic esg, input logic efl, input logic est);
        vec_t v;
        v.s = s; v.c = c; v.sub = sub; v.corr = corr; v.emv = emv; v.halt = halt;
        v.sa = sa; v.bc = bc; v.ah = ah;
        v.e_sum = es; v.e_sign = esg; v.e_flip = efl; v.e_sticky = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        ifc.valid_i        = 1'b1;
        ifc.csa_sum_i      = v.s;
        ifc.csa_carry_i    = v.c;
        ifc.sub_i          = v.sub;
        ifc.corr_sign_i    = v.corr;
        ifc.exp_mv_sign_i  = v.emv;
        ifc.mv_halt_i      = v.halt;
        ifc.sign_aligned_i = v.sa;
        ifc.a_high_i       = v.ah;
        ifc.bc_special_i   = v.bc;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input vec_t v);
        bit acc = 1'b0;
        int n   = 0;
        exp_t e;
        drive(v);
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = ifc.ready_o;
            @(posedge clk_i);
            n++;
        end
        if (acc) begin
            e.sum = v.e_sum; e.sign = v.e_sign; e.flip = v.e_flip; e.sticky = v.e_sticky;
            exp_q.push_back(e);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ready_o stayed %0b, required 1", ifc.ready_o);
        end
        #1;
        ifc.valid_i = 1'b0;
    endtask

    task automatic send_lat(input vec_t v, input string tag);
        send(v);
        @(negedge clk_i);
        check({tag, "_valid_lat1"}, ifc.valid_o, 0);
        @(negedge clk_i);
        check({tag, "_valid_lat2"}, ifc.valid_o, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && ifc.valid_o && ifc.ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got pos_sum %0h with no beat outstanding", ifc.pos_sum_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pos_sum", ifc.pos_sum_o, e.sum);
                    check("adder_sign", ifc.adder_sign_o, e.sign);
                    check("sign_flip", ifc.sign_flip_o, e.flip);
                    check("minus_sticky", ifc.minus_sticky_o, e.sticky);
                end
            end
        end
    end

    initial begin : stimulus
        logic [SUM_W-1:0] held;
        longint t0;

        //            S                  C                  sub corr emv halt sa bc a_high        pos_sum                               sign flip sticky
        vecs[0]  = mk(48'd3,             48'd4,             0,  1,   0,  1,   0, 0, 27'd0,        74'd11,                                0, 0, 0);
        vecs[1]  = mk(48'd0,             48'd0,             0,  1,   0,  0,   1, 0, 27'd5,        {26'd5, 48'd0},                        1, 0, 0);
        // lci is 0 here, so the negated high part wraps ~a_high - 1 to all ones.
        vecs[2]  = mk(48'd0,             48'd0,             0,  1,   0,  0,   0, 0, 27'h7FFFFFF,  {26'h3FFFFFF, 48'd0},                  1, 1, 0);
        vecs[3]  = mk(48'd0,             48'd0,             1,  1,   1,  0,   1, 0, 27'd1,        {26'd0, 1'b1, 47'd0},                  1, 0, 1);
        vecs[4]  = mk(48'd5,             48'd0,             0,  0,   0,  0,   0, 0, 27'd0,        {26'd1, 48'd5},                        0, 0, 0);
        vecs[5]  = mk(48'd0,             48'd0,             1,  1,   0,  0,   1, 0, 27'h7FFFFFE,  {26'd1, 48'hFFFFFFFFFFFF},             0, 1, 0);
        vecs[6]  = mk(48'd0,             48'd0,             0,  1,   1,  0,   0, 1, 27'd3,        {26'd3, 48'd0},                        0, 0, 0);
        vecs[7]  = mk(48'd7,             48'd1,             1,  1,   1,  1,   1, 0, 27'd0,        74'd10,                                1, 0, 1);
        vecs[8]  = mk(48'd0,             48'h800000000000,  0,  1,   0,  0,   0, 0, 27'h10,       {26'h11, 48'd0},                       0, 0, 0);
        vecs[9]  = mk(48'd0,             48'd0,             1,  1,   1,  0,   0, 1, 27'd1,        {26'd1, 48'd0},                        0, 0, 0);
        vecs[10] = mk(48'd0,             48'd0,             1,  1,   1,  0,   1, 0, 27'd0,        {27'h7FFFFFF, 47'd0},                  1, 0, 1);

        rst_ni  = 1'b0;
        flush_i = 1'b0;
        ifc.ready_i = 1'b1;
        drive(vecs[0]);
        ifc.valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid_o", ifc.valid_o, 0);
        check("rst_ready_o", ifc.ready_o, 1);
        check("rst_pos_sum", ifc.pos_sum_o, 0);
        check("rst_flags", {ifc.adder_sign_o, ifc.sign_flip_o, ifc.minus_sticky_o}, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        send_lat(vecs[0], "first");
        wait_empty("first");

        t0 = $time;
        for (int i = 1; i <= 10; i++) send(vecs[i]);
        check("throughput_cycles", ($time - t0) / 10, 10);
        wait_empty("stream");

        ifc.ready_i = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(vecs[i]);
            end
            begin
                repeat (3) @(negedge clk_i);
                check("stall_ready_o", ifc.ready_o, 0);
                check("stall_valid_o", ifc.valid_o, 1);
                held = ifc.pos_sum_o;
                @(negedge clk_i);
                check("stall_hold_valid", ifc.valid_o, 1);
                check("stall_hold_sum", ifc.pos_sum_o, held);
                @(posedge clk_i);
                #1;
                ifc.ready_i = 1'b1;
            end
        join
        wait_empty("stall");

        ifc.ready_i = 1'b0;
        send(vecs[5]);
        send(vecs[6]);
        flush_i = 1'b1;
        drive(vecs[7]);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        ifc.valid_i = 1'b0;
        check("flush_valid_o", ifc.valid_o, 0);
        check("flush_ready_o", ifc.ready_o, 1);
        exp_q.delete();
        ifc.ready_i = 1'b1;
        send_lat(vecs[8], "post_flush");
        wait_empty("post_flush");

        ifc.ready_i = 1'b0;
        send(vecs[9]);
        send(vecs[10]);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid_o", ifc.valid_o, 0);
        check("arst_ready_o", ifc.ready_o, 1);
        check("arst_pos_sum", ifc.pos_sum_o, 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ifc.ready_i = 1'b1;
        send_lat(vecs[0], "post_reset");
        wait_empty("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
